// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits resolve in the lookup cycle; misses run write-back then refill over a req/ack handshake.
module dcache_ctrl #(
    parameter int unsigned SETS   = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned WSEL_W = $clog2(LINE_W / 32);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned BIT_W  = WSEL_W + 5;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

    state_e            state_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [ADDR_W-1:0] victim_addr_q;
    logic [ADDR_W-1:0] refill_addr_q;
    logic [LINE_W-1:0] victim_line_q;

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  refill_idx;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  refill_tag;
    logic [BIT_W-1:0]  word_bit;
    logic              hit;
    logic              lookup;
    logic              unused_addr;

    assign idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign word_bit    = {cpu_addr_i[2 +: WSEL_W], 5'd0};
    assign refill_idx  = refill_addr_q[OFF_W +: IDX_W];
    assign refill_tag  = refill_addr_q[ADDR_W-1 -: TAG_W];
    assign lookup      = (state_q == StIdle) && cpu_req_i;
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign unused_addr = ^{cpu_addr_i[1:0], refill_addr_q[OFF_W-1:0]};

    // Memory-side outputs depend on state registers only; CPU side is decided in the lookup cycle.
    always_comb begin
        cpu_rdata_o = '0;
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                cpu_stall_o = cpu_req_i && !hit;
                if (cpu_req_i && hit && !cpu_write_i) begin
                    cpu_rdata_o = data_q[idx][word_bit +: 32];
                end
            end
            StWriteback: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = victim_addr_q;
                mem_wdata_o = victim_line_q;
            end
            StRefill: begin
                mem_req_o  = 1'b1;
                mem_addr_o = refill_addr_q;
            end
            default: cpu_stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (lookup && hit && cpu_write_i) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (lookup && !hit) begin
                        victim_addr_q <= {tag_q[idx], idx, {OFF_W{1'b0}}};
                        victim_line_q <= data_q[idx];
                        refill_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                        state_q       <= (valid_q[idx] && dirty_q[idx]) ? StWriteback : StRefill;
                    end
                end
                StWriteback: begin
                    if (mem_ack_i) state_q <= StRefill;
                end
                StRefill: begin
                    if (mem_ack_i) begin
                        valid_q[refill_idx] <= 1'b1;
                        dirty_q[refill_idx] <= 1'b0;
                        state_q             <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone decides whether they are meaningful.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (lookup && hit && cpu_write_i) begin
                data_q[idx][word_bit +: 32] <= cpu_wdata_i;
            end else if (state_q == StRefill && mem_ack_i) begin
                data_q[refill_idx] <= mem_rdata_i;
                tag_q[refill_idx]  <= refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transparent-memory reference model.
module tb_dcache_ctrl;
    localparam int unsigned SETS   = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic              cpu_write;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [255:0]      mem_wdata;
    logic [255:0]      mem_rdata;
    logic              mem_ack;

    always #5 clk = ~clk;

    dcache_ctrl #(.SETS(SETS), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Backing memory (line-keyed) and the CPU-visible flat word memory the cache must emulate.
    logic [255:0] bmem [int unsigned];
    logic [31:0]  gold [int unsigned];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a & ~32'h3) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (bmem.exists(la)) return bmem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = a >> 2;
        if (gold.exists(wa)) return gold[wa];
        return init_word(a);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_rd(la + 32'(w * 4));
        return l;
    endfunction

    // Residency model: which line address each set holds and whether it is dirty.
    logic [31:0] res_line [SETS];
    bit          res_v    [SETS];
    bit          res_d    [SETS];

    typedef struct {
        int          n;
        bit          wb;
        logic [31:0] wb_addr;
        logic [255:0] wb_data;
        logic [31:0] rf_addr;
        int          stalls;
        logic [31:0] rdata;
    } pred_t;

    task automatic model_step(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input int lat, output pred_t p);
        logic [31:0] la;
        int          s;
        la = a & ~32'h1F;
        s = int'((a >> 5) % SETS);
        p.n = 0; p.wb = 0; p.wb_addr = '0; p.wb_data = '0; p.rf_addr = la;
        p.stalls = 0; p.rdata = '0;
        if (!(res_v[s] && res_line[s] == la)) begin
            if (res_v[s] && res_d[s]) begin
                p.wb = 1; p.wb_addr = res_line[s]; p.wb_data = gold_line(res_line[s]);
                p.n = 2; p.stalls = 2 * lat + 3;
            end else begin
                p.n = 1; p.stalls = lat + 2;
            end
            res_line[s] = la; res_v[s] = 1; res_d[s] = 0;
        end
        if (w) begin
            gold[a >> 2] = d;
            res_d[s] = 1;
        end else begin
            p.rdata = gold_rd(a);
        end
    endtask

    // Reset throws away dirty lines: the visible memory reverts to what the backing store holds.
    task automatic model_reset();
        logic [255:0] ln;
        for (int s = 0; s < int'(SETS); s++) begin
            if (res_v[s] && res_d[s]) begin
                ln = mem_line(res_line[s]);
                for (int w = 0; w < 8; w++) gold[(res_line[s] >> 2) + 32'(w)] = ln[w*32 +: 32];
            end
            res_v[s] = 0;
            res_d[s] = 0;
        end
    endtask

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        bit           stable;
    } txn_t;

    txn_t        txq[$];
    int          cur_lat;
    int          req_cyc;
    logic [31:0] first_addr;
    bit          first_wr;
    bit          stable;

    // Called at each falling edge; schedules the ack for the next rising edge.
    task automatic mem_respond();
        if (mem_req) begin
            if (req_cyc == 0) begin
                first_addr = mem_addr; first_wr = mem_write; stable = 1'b1;
            end else if (mem_addr !== first_addr || mem_write !== first_wr) begin
                stable = 1'b0;
            end
            if (req_cyc == cur_lat) begin
                mem_ack = 1'b1;
                txq.push_back('{mem_write, mem_addr, mem_wdata, stable});
                if (mem_write) bmem[mem_addr] = mem_wdata;
                else mem_rdata = mem_line(mem_addr);
                req_cyc = 0;
            end else begin
                mem_ack = 1'b0;
                req_cyc++;
            end
        end else begin
            mem_ack = 1'b0;
            req_cyc = 0;
        end
    endtask

    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input int lat,
                          output int stalls, output logic [31:0] rd, output bit req_at_hit);
        bit done;
        txq.delete();
        cur_lat = lat;
        req_cyc = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
        stalls = 0; rd = '0; req_at_hit = 1'b1; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            mem_respond();
            if (!cpu_stall) begin
                rd = cpu_rdata; req_at_hit = mem_req; done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %h still stalled after 400 cycles", a);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_write = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic run_checked(input string tag, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input int lat);
        pred_t       p;
        int          st;
        logic [31:0] rd;
        bit          rq;
        model_step(w, a, d, lat, p);
        access(w, a, d, lat, st, rd, rq);
        chk32({tag, " stalls"}, st, p.stalls);
        chk32({tag, " rdata"}, rd, p.rdata);
        chk32({tag, " mem_req_at_hit"}, 32'(rq), 32'd0);
        chk32({tag, " txn_count"}, txq.size(), p.n);
        if (txq.size() == p.n && p.n > 0) begin
            if (p.wb) begin
                chk32({tag, " wb_write"}, 32'(txq[0].wr), 32'd1);
                chk32({tag, " wb_addr"}, txq[0].addr, p.wb_addr);
                chkw({tag, " wb_data"}, txq[0].wdata, p.wb_data);
            end
            chk32({tag, " rf_write"}, 32'(txq[p.n-1].wr), 32'd0);
            chk32({tag, " rf_addr"}, txq[p.n-1].addr, p.rf_addr);
            chkw({tag, " rf_wdata"}, txq[p.n-1].wdata, '0);
            chk32({tag, " rf_stable"}, 32'(txq[p.n-1].stable), 32'd1);
        end
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        int          stalls;
        logic [31:0] rdata;
        int          ntx;
        logic [31:0] wb_addr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        pred_t        p;
        int           st;
        logic [31:0]  rd;
        bit           rq;
        logic [31:0]  ra;
        string        nm;

        vecs[0] = '{0, 32'h0000_0040, 32'h0,         3,  5,  init_word(32'h40),  1, 32'h0};
        vecs[1] = '{0, 32'h0000_0044, 32'h0,         0,  0,  init_word(32'h44),  0, 32'h0};
        vecs[2] = '{1, 32'h0000_0048, 32'hDEADBEEF,  0,  0,  32'h0,              0, 32'h0};
        vecs[3] = '{0, 32'h0000_0048, 32'h0,         0,  0,  32'hDEADBEEF,       0, 32'h0};
        vecs[4] = '{0, 32'h0000_0448, 32'h0,         2,  7,  init_word(32'h448), 2, 32'h40};
        vecs[5] = '{0, 32'h0000_0048, 32'h0,         1,  3,  32'hDEADBEEF,       1, 32'h0};
        vecs[6] = '{1, 32'h0000_1000, 32'hC0FFEE00,  0,  2,  32'h0,              1, 32'h0};
        vecs[7] = '{0, 32'h0000_1000, 32'h0,         0,  0,  32'hC0FFEE00,       0, 32'h0};
        vecs[8] = '{0, 32'h0000_0860, 32'h0,         20, 22, init_word(32'h860), 1, 32'h0};

        rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        req_cyc = 0; cur_lat = 0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk32("reset mem_req", 32'(mem_req), 32'd0);
        chk32("reset mem_write", 32'(mem_write), 32'd0);
        chk32("reset mem_addr", mem_addr, 32'd0);
        chkw("reset mem_wdata", mem_wdata, '0);
        chk32("reset stall", 32'(cpu_stall), 32'd0);
        chk32("reset rdata", cpu_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            nm = $sformatf("vec%0d", i);
            model_step(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lat, p);
            access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lat, st, rd, rq);
            chk32({nm, " stalls"}, st, vecs[i].stalls);
            chk32({nm, " rdata"}, rd, vecs[i].rdata);
            chk32({nm, " txn_count"}, txq.size(), vecs[i].ntx);
            if (vecs[i].ntx == 2 && txq.size() == 2) begin
                chk32({nm, " wb_addr"}, txq[0].addr, vecs[i].wb_addr);
                chk32({nm, " wb_write"}, 32'(txq[0].wr), 32'd1);
                chk32({nm, " wb_word2"}, txq[0].wdata[95:64], 32'hDEADBEEF);
            end
            if (vecs[i].ntx > 0 && txq.size() == vecs[i].ntx) begin
                ra = vecs[i].a & ~32'h1F;
                chk32({nm, " rf_addr"}, txq[vecs[i].ntx-1].addr, ra);
                chk32({nm, " rf_write"}, 32'(txq[vecs[i].ntx-1].wr), 32'd0);
                chk32({nm, " rf_stable"}, 32'(txq[vecs[i].ntx-1].stable), 32'd1);
            end
        end

        // Stray ack while idle must not disturb anything.
        mem_rdata = '1;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk32("idle_ack mem_req", 32'(mem_req), 32'd0);
        chk32("idle_ack stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        run_checked("idle_ack reload", 0, 32'h0000_0864, 32'h0, 0);

        // Reset in the middle of a refill aborts it.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_2060; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk32("abort mem_req", 32'(mem_req), 32'd1);
        chk32("abort mem_write", 32'(mem_write), 32'd0);
        chk32("abort mem_addr", mem_addr, 32'h0000_2060);
        chk32("abort stall", 32'(cpu_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk32("post_abort mem_req", 32'(mem_req), 32'd0);
        chk32("post_abort stall", 32'(cpu_stall), 32'd0);
        chk32("post_abort mem_addr", mem_addr, 32'd0);
        model_reset();
        run_checked("reissue", 0, 32'h0000_2060, 32'h0, 0);
        run_checked("discarded_store", 0, 32'h0000_1000, 32'h0, 1);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ((($urandom_range(0, 3) * SETS) + $urandom_range(0, 7)) << 5)
                | ($urandom_range(0, 7) << 2);
            run_checked($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                        int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate L1 data cache controller between the pipeline MEM stage and the line-wide data memory. It holds the tag, valid, dirty and data arrays. It resolves hits in a single cycle and sequences misses through write-back and refill over a req/ack memory handshake. While a miss is in service it stalls the pipeline.

Parameters:
SETS, 32, number of lines; power of two, at least 2
LINE_W, 256, line width in bits; 8 words of 32 bits
ADDR_W, 32, byte address width

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, synchronous, active-high
cpu_req_i  in  1  MEM stage issues a load or store
cpu_write_i  in  1  1 = store, 0 = load
cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
cpu_wdata_i  in  32  store data
cpu_rdata_o  out  32  load data; valid on a hit cycle
cpu_stall_o  out  1  freeze the pipeline; CPU holds request inputs stable while high
mem_req_o  out  1  memory request
mem_write_o  out  1  1 = write-back, 0 = refill
mem_addr_o  out  ADDR_W  line-aligned address; low log2(LINE_W/8) bits are 0
mem_wdata_o  out  LINE_W  victim line data
mem_rdata_i  in  LINE_W  refill data; valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split: offset = [4:0], word select = [4:2], index = next log2(SETS) bits, tag = remaining upper bits.
- States: IDLE, WRITEBACK, REFILL.
- Reset (rst_i high at an edge):
  - state goes to IDLE; every valid and dirty bit clears.
  - Data and tag arrays are not cleared.
  - mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, cpu_rdata_o and cpu_stall_o are 0 from the next cycle on.
- IDLE, cpu_req_i low: cpu_stall_o = 0, mem_req_o = 0, cpu_rdata_o = 0.
- IDLE, hit (valid[index] and tag match), decided combinationally in the same cycle:
  - cpu_stall_o = 0.
  - Load: cpu_rdata_o = selected word; zero latency.
  - Store: at the edge, the selected word is written and dirty[index] set to 1; cpu_rdata_o = 0.
- IDLE, miss:
  - cpu_stall_o = 1 combinationally in the same cycle.
  - Next state is WRITEBACK if the victim is valid and dirty, otherwise REFILL.
  - Victim address {old tag, index, 0} and victim line are captured at this edge.
- WRITEBACK:
  - mem_req_o = 1, mem_write_o = 1, mem_addr_o = victim address, mem_wdata_o = victim line, cpu_stall_o = 1.
  - Outputs hold until mem_ack_i; on ack, go to REFILL.
- REFILL:
  - mem_req_o = 1, mem_write_o = 0, mem_addr_o = {cpu tag, index, 0}, mem_wdata_o = 0, cpu_stall_o = 1.
  - On mem_ack_i: line = mem_rdata_i, tag = cpu tag, valid = 1, dirty = 0, then go to IDLE.
- After refill, IDLE re-evaluates the held request, which now hits:
  - stall drops and a store merges its word, setting dirty.
  - Total miss cost = memory wait cycles + 1 re-lookup cycle.
- mem_req_o never drops before mem_ack_i; mem_ack_i while mem_req_o is low is ignored.
- Zero-wait memory (ack in the first request cycle) is legal: a clean miss costs 2 cycles, a dirty miss 3.
- Reset mid-WRITEBACK or mid-REFILL aborts the transaction:
  - mem_req_o is 0 the next cycle.
  - Dirty data still in the cache is discarded.
- cpu_req_i dropping during a miss is a CPU protocol violation; the controller completes the current state sequence regardless.
- A store miss allocates the line (refill first), then merges the word; no write-through.

Test Plan:
1. Cold load 0x0000_0040; ack 3 cycles after mem_req_o -> stall 4+1 cycles, mem_write_o = 0, mem_addr_o = 0x40; then cpu_rdata_o = word 0 of the refill line, stall 0.
2. Load 0x44 right after case 1 -> stall 0 in the same cycle, cpu_rdata_o = refill word 1, mem_req_o stays 0.
3. Store 0xDEADBEEF to 0x48 (hit), then load 0x48 -> no stall; the load returns 0xDEADBEEF; line 2 dirty.
4. Load 0x0000_0448 (same index, new tag) -> WRITEBACK first with addr 0x40 and mem_wdata_o word 2 = 0xDEADBEEF; then REFILL at 0x440; clean result.
5. Miss with mem_ack_i held low 20 cycles -> mem_req_o and mem_addr_o stable for all 20 cycles; stall high throughout; an ack pulse in IDLE is ignored.
6. rst_i high during REFILL -> next cycle mem_req_o = 0, cpu_stall_o = 0, state IDLE; re-issuing the load misses again as a cold miss.
